// File: rtl/fib_job_scheduler.sv
// rtl/fib_job_scheduler.sv - round-robin scheduler sharing one Fibonacci engine among NREQ requesters
//
// Purpose:
//   Arbitrates NREQ requesters round-robin onto a single Fibonacci engine,
//   runs one job at a time, returns the result to the winner, pulses the
//   engine back to idle after every job and aborts a hung job with an
//   error response after TIMEOUT cycles in WAIT.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   req            per-requester request level
//   req_i          packed indices, requester k at [k*IW +: IW]
//   resp_valid     one-hot, one-cycle response strobe
//   resp_f         result, valid while any resp_valid bit is high
//   resp_err       watchdog error flag, valid with resp_valid
//   busy           high in every state except IDLE
//   eng_ready      engine idle indication
//   eng_start      one-cycle engine start
//   eng_i          index presented to the engine
//   eng_done_tick  engine completion strobe
//   eng_f          engine result
//   eng_clear      one-cycle pulse returning the engine from done to idle
module fib_job_scheduler #(
   parameter int NREQ    = 4,
   parameter int IW      = 3,
   parameter int FW      = 20,
   parameter int TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*IW-1:0] req_i,
   output logic [NREQ-1:0]    resp_valid,
   output logic [FW-1:0]      resp_f,
   output logic               resp_err,
   output logic               busy,
   input  logic               eng_ready,
   output logic               eng_start,
   output logic [IW-1:0]      eng_i,
   input  logic               eng_done_tick,
   input  logic [FW-1:0]      eng_f,
   output logic               eng_clear
);

   localparam int PW = $clog2(NREQ);
   localparam int CW = $clog2(TIMEOUT);
   // Last count value before the watchdog fires; TIMEOUT-1 always fits in CW bits.
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP,
      ST_CLEAR
   } state_t;

   state_t         state;
   state_t         state_nx;

   logic [PW-1:0]  rr_ptr;
   logic [PW-1:0]  win_id;
   logic [IW-1:0]  win_i;
   logic [CW-1:0]  wd_cnt;
   logic           err_q;

   logic [PW-1:0]  pick_id;
   logic           pick_found;
   logic [IW-1:0]  req_idx [NREQ];

   logic           grant;
   logic           wait_done;
   logic           wait_timeout;

   // Unpack the per-requester indices so the winner's index is a plain array read.
   always_comb begin
      for (int k = 0; k < NREQ; k++) begin
         req_idx[k] = req_i[k*IW +: IW];
      end
   end

   // Round-robin pick: scan rr_ptr+1, rr_ptr+2, ... modulo NREQ, first set bit wins.
   // rr_ptr holds the last winner, so the last-served requester is scanned last.
   always_comb begin
      logic [PW-1:0] cand;
      pick_found = 1'b0;
      pick_id    = '0;
      cand       = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = PW'((int'(rr_ptr) + k) % NREQ);
         if (!pick_found && req[cand]) begin
            pick_found = 1'b1;
            pick_id    = cand;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic and outputs decoded from registered state only.
   always_comb begin
      state_nx     = state;
      grant        = 1'b0;
      wait_done    = 1'b0;
      wait_timeout = 1'b0;
      busy         = 1'b1;
      eng_start    = 1'b0;
      eng_clear    = 1'b0;
      resp_err     = 1'b0;
      resp_valid   = '0;

      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (pick_found && eng_ready) begin
               grant    = 1'b1;
               state_nx = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            eng_start = 1'b1;
            state_nx  = ST_WAIT;
         end
         ST_WAIT: begin
            // A completion in the last watchdog cycle still counts as success.
            if (eng_done_tick) begin
               wait_done = 1'b1;
               state_nx  = ST_RESP;
            end else if (wd_cnt == CNT_LAST) begin
               wait_timeout = 1'b1;
               state_nx     = ST_RESP;
            end
         end
         ST_RESP: begin
            resp_err = err_q;
            for (int k = 0; k < NREQ; k++) begin
               resp_valid[k] = (win_id == PW'(k));
            end
            state_nx = ST_CLEAR;
         end
         ST_CLEAR: begin
            eng_clear = 1'b1;
            state_nx  = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Job datapath: winner latch, watchdog counter and response capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr <= PW'(NREQ - 1);
         win_id <= '0;
         win_i  <= '0;
         wd_cnt <= '0;
         resp_f <= '0;
         err_q  <= 1'b0;
      end else begin
         if (grant) begin
            win_id <= pick_id;
            win_i  <= req_idx[pick_id];
            rr_ptr <= pick_id;
         end

         // The counter stops at CNT_LAST because WAIT is left on that cycle,
         // so it never wraps before the compare.
         if (state == ST_ISSUE) begin
            wd_cnt <= '0;
         end else if (state == ST_WAIT && !wait_done && !wait_timeout) begin
            wd_cnt <= wd_cnt + 1'b1;
         end

         if (wait_done) begin
            resp_f <= eng_f;
            err_q  <= 1'b0;
         end else if (wait_timeout) begin
            resp_f <= '0;
            err_q  <= 1'b1;
         end
      end
   end

   // The latched index is held through ISSUE and WAIT.
   assign eng_i = win_i;

endmodule

// File: tb/tb_fib_job_scheduler.sv
// tb/tb_fib_job_scheduler.sv - self-checking bench for fib_job_scheduler
module tb_fib_job_scheduler;

   localparam int NREQ    = 4;
   localparam int IW      = 3;
   localparam int FW      = 20;
   localparam int TIMEOUT = 64;

   logic               clk = 1'b0;
   logic               reset;
   logic [NREQ-1:0]    req;
   logic [NREQ*IW-1:0] req_i;
   logic [NREQ-1:0]    resp_valid;
   logic [FW-1:0]      resp_f;
   logic               resp_err;
   logic               busy;
   logic               eng_ready;
   logic               eng_start;
   logic [IW-1:0]      eng_i;
   logic               eng_done_tick = 1'b0;
   logic [FW-1:0]      eng_f = '0;
   logic               eng_clear;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Engine stub controls and observations.
   logic               ready_low = 1'b0;
   logic               eng_hang  = 1'b0;
   int                 eng_lat   = 2;
   logic               eng_idle  = 1'b1;
   int                 e_st      = 0;
   int                 e_cnt     = 0;
   logic [IW-1:0]      e_idx     = '0;
   int                 start_cyc = 0;
   int                 done_cyc  = 0;

   fib_job_scheduler #(
      .NREQ(NREQ), .IW(IW), .FW(FW), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .req(req),
      .req_i(req_i),
      .resp_valid(resp_valid),
      .resp_f(resp_f),
      .resp_err(resp_err),
      .busy(busy),
      .eng_ready(eng_ready),
      .eng_start(eng_start),
      .eng_i(eng_i),
      .eng_done_tick(eng_done_tick),
      .eng_f(eng_f),
      .eng_clear(eng_clear)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [FW-1:0] fib(input int n);
      int a, b, t;
      a = 0;
      b = 1;
      for (int k = 0; k < n; k++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return a[FW-1:0];
   endfunction

   // Behavioural engine: idle -> running (eng_lat cycles) -> done, back to idle on eng_clear.
   assign eng_ready = eng_idle && !ready_low;

   always @(negedge clk) begin
      if (reset) begin
         e_st          = 0;
         eng_done_tick = 1'b0;
         eng_f         = '0;
      end else begin
         eng_done_tick = 1'b0;
         if (eng_clear) begin
            e_st = 0;
         end else begin
            case (e_st)
               0: if (eng_start) begin
                     e_st      = 1;
                     e_cnt     = eng_lat;
                     e_idx     = eng_i;
                     start_cyc = cyc;
                  end
               1: if (!eng_hang) begin
                     if (e_cnt == 0) begin
                        eng_done_tick = 1'b1;
                        eng_f         = fib(int'(e_idx));
                        done_cyc      = cyc;
                        e_st          = 2;
                     end else begin
                        e_cnt = e_cnt - 1;
                     end
                  end
               default: ;
            endcase
         end
      end
      eng_idle = (e_st == 0);
   end

   task automatic wait_resp(input int budget, output logic ok, output int at);
      ok = 1'b0;
      at = 0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (resp_valid != '0) begin
            ok = 1'b1;
            at = cyc;
            break;
         end
      end
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (!busy && eng_idle) break;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      req_i = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      req       = '0;
      req_i     = '0;
      ready_low = 1'b0;
      eng_hang  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (resp_valid !== '0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
      checks++; if (resp_f !== '0) begin errors++; $display("FAIL reset_resp_f got=%0d exp=0", resp_f); end
      checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got=%b exp=0", resp_err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (eng_start !== 1'b0) begin errors++; $display("FAIL reset_eng_start got=%b exp=0", eng_start); end
      checks++; if (eng_i !== '0) begin errors++; $display("FAIL reset_eng_i got=%0d exp=0", eng_i); end
      checks++; if (eng_clear !== 1'b0) begin errors++; $display("FAIL reset_eng_clear got=%b exp=0", eng_clear); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single();
      logic ok;
      int   at;
      eng_lat    = 3;
      req        = 4'b0001;
      req_i[2:0] = 3'd7;
      @(negedge clk);
      checks++; if (eng_start !== 1'b1) begin errors++; $display("FAIL single_start got=%b exp=1", eng_start); end
      checks++; if (eng_i !== 3'd7) begin errors++; $display("FAIL single_eng_i got=%0d exp=7", eng_i); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
      wait_resp(40, ok, at);
      checks++; if (!ok) begin errors++; $display("FAIL single_timeout got=none exp=resp"); end
      checks++; if (resp_valid !== 4'b0001) begin errors++; $display("FAIL single_valid got=%b exp=0001", resp_valid); end
      checks++; if (resp_f !== 20'd13) begin errors++; $display("FAIL single_f got=%0d exp=13", resp_f); end
      checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL single_err got=%b exp=0", resp_err); end
      checks++; if (at !== done_cyc + 1) begin errors++; $display("FAIL single_resp_lat got=%0d exp=%0d", at, done_cyc + 1); end
      req = '0;
      @(negedge clk);
      checks++; if (eng_clear !== 1'b1) begin errors++; $display("FAIL single_clear got=%b exp=1", eng_clear); end
      checks++; if (resp_valid !== '0) begin errors++; $display("FAIL single_valid_len got=%b exp=0", resp_valid); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_back_idle got=%b exp=0", busy); end
   endtask

   task automatic test_boundary();
      logic          ok;
      int            at;
      logic [FW-1:0] exp_f [3];
      exp_f[0] = 20'd0;
      exp_f[1] = 20'd1;
      exp_f[2] = 20'd1;
      for (int i = 0; i < 3; i++) begin
         eng_lat    = int'($urandom_range(0, 4));
         req_i      = '0;
         req_i[8:6] = 3'(i);
         req        = 4'b0100;
         wait_resp(40, ok, at);
         checks++; if (!ok) begin errors++; $display("FAIL bound_timeout i=%0d got=none exp=resp", i); end
         checks++; if (resp_valid !== 4'b0100) begin errors++; $display("FAIL bound_valid i=%0d got=%b exp=0100", i, resp_valid); end
         checks++; if (resp_f !== exp_f[i]) begin errors++; $display("FAIL bound_f i=%0d got=%0d exp=%0d", i, resp_f, exp_f[i]); end
         req = '0;
         wait_idle();
      end
   endtask

   task automatic test_round_robin();
      logic          ok;
      int            at;
      int            prev_done;
      int            exp_id [5];
      logic [FW-1:0] exp_f [5];
      exp_id = '{0, 1, 2, 3, 0};
      exp_f  = '{20'd2, 20'd3, 20'd5, 20'd8, 20'd2};
      do_reset();
      prev_done = 0;
      req_i = {3'd6, 3'd5, 3'd4, 3'd3};
      req   = 4'b1111;
      for (int j = 0; j < 5; j++) begin
         eng_lat = int'($urandom_range(0, 4));
         wait_resp(40, ok, at);
         checks++; if (!ok) begin errors++; $display("FAIL rr_timeout j=%0d got=none exp=resp", j); end
         checks++; if (resp_valid !== 4'(1 << exp_id[j])) begin errors++; $display("FAIL rr_valid j=%0d got=%b exp=%b", j, resp_valid, 4'(1 << exp_id[j])); end
         checks++; if (resp_f !== exp_f[j]) begin errors++; $display("FAIL rr_f j=%0d got=%0d exp=%0d", j, resp_f, exp_f[j]); end
         if (j > 0) begin
            checks++; if (start_cyc !== prev_done + 4) begin errors++; $display("FAIL rr_gap j=%0d got=%0d exp=%0d", j, start_cyc - prev_done, 4); end
         end
         prev_done = done_cyc;
      end
      req = '0;
      wait_idle();
   endtask

   task automatic test_watchdog();
      logic ok;
      int   at;
      eng_hang   = 1'b1;
      req_i      = '0;
      req_i[2:0] = 3'd5;
      req        = 4'b0001;
      wait_resp(TIMEOUT + 30, ok, at);
      checks++; if (!ok) begin errors++; $display("FAIL wd_timeout got=none exp=resp"); end
      checks++; if (at !== start_cyc + 1 + TIMEOUT) begin errors++; $display("FAIL wd_when got=%0d exp=%0d", at, start_cyc + 1 + TIMEOUT); end
      checks++; if (resp_err !== 1'b1) begin errors++; $display("FAIL wd_err got=%b exp=1", resp_err); end
      checks++; if (resp_f !== '0) begin errors++; $display("FAIL wd_f got=%0d exp=0", resp_f); end
      checks++; if (resp_valid !== 4'b0001) begin errors++; $display("FAIL wd_valid got=%b exp=0001", resp_valid); end
      req = '0;
      @(negedge clk);
      checks++; if (eng_clear !== 1'b1) begin errors++; $display("FAIL wd_clear got=%b exp=1", eng_clear); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wd_idle got=%b exp=0", busy); end
      eng_hang   = 1'b0;
      eng_lat    = TIMEOUT - 1;
      req_i[2:0] = 3'd6;
      req        = 4'b0001;
      wait_resp(TIMEOUT + 30, ok, at);
      checks++; if (!ok) begin errors++; $display("FAIL wd_last_timeout got=none exp=resp"); end
      checks++; if (at !== start_cyc + 1 + TIMEOUT) begin errors++; $display("FAIL wd_last_when got=%0d exp=%0d", at, start_cyc + 1 + TIMEOUT); end
      checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL wd_last_err got=%b exp=0", resp_err); end
      checks++; if (resp_f !== 20'd8) begin errors++; $display("FAIL wd_last_f got=%0d exp=8", resp_f); end
      req = '0;
      wait_idle();
   endtask

   task automatic test_not_ready();
      logic ok;
      int   at;
      int   bad_start;
      int   bad_busy;
      ready_low  = 1'b1;
      eng_lat    = 1;
      req_i      = '0;
      req_i[5:3] = 3'd4;
      req        = 4'b0010;
      bad_start  = 0;
      bad_busy   = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (eng_start !== 1'b0) bad_start++;
         if (busy !== 1'b0) bad_busy++;
      end
      checks++; if (bad_start != 0) begin errors++; $display("FAIL nr_start got=%0d exp=0", bad_start); end
      checks++; if (bad_busy != 0) begin errors++; $display("FAIL nr_busy got=%0d exp=0", bad_busy); end
      ready_low = 1'b0;
      @(negedge clk);
      checks++; if (eng_start !== 1'b1) begin errors++; $display("FAIL nr_release_start got=%b exp=1", eng_start); end
      wait_resp(40, ok, at);
      checks++; if (resp_valid !== 4'b0010) begin errors++; $display("FAIL nr_valid got=%b exp=0010", resp_valid); end
      checks++; if (resp_f !== 20'd3) begin errors++; $display("FAIL nr_f got=%0d exp=3", resp_f); end
      req = '0;
      wait_idle();
   endtask

   task automatic test_reset_mid();
      logic ok;
      int   at;
      eng_lat    = 20;
      req_i      = '0;
      req_i[2:0] = 3'd4;
      req        = 4'b0001;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (eng_start) break;
      end
      @(negedge clk);
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_busy_before got=%b exp=1", busy); end
      reset = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got=%b exp=0", busy); end
      checks++; if (resp_f !== '0) begin errors++; $display("FAIL rm_resp_f got=%0d exp=0", resp_f); end
      checks++; if (eng_i !== '0) begin errors++; $display("FAIL rm_eng_i got=%0d exp=0", eng_i); end
      checks++; if ({resp_valid, resp_err, eng_start, eng_clear} !== '0) begin errors++; $display("FAIL rm_strobes got=%b exp=0", {resp_valid, resp_err, eng_start, eng_clear}); end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checks++; if (resp_valid !== '0) begin errors++; $display("FAIL rm_no_resp got=%b exp=0", resp_valid); end
      end
      req_i       = '0;
      req_i[2:0]  = 3'd5;
      req_i[11:9] = 3'd7;
      req         = 4'b1001;
      eng_lat     = 2;
      reset       = 1'b0;
      wait_resp(40, ok, at);
      checks++; if (resp_valid !== 4'b0001) begin errors++; $display("FAIL rm_tie_valid got=%b exp=0001", resp_valid); end
      checks++; if (resp_f !== 20'd5) begin errors++; $display("FAIL rm_tie_f got=%0d exp=5", resp_f); end
      req = 4'b1000;
      wait_resp(40, ok, at);
      checks++; if (resp_valid !== 4'b1000) begin errors++; $display("FAIL rm_next_valid got=%b exp=1000", resp_valid); end
      checks++; if (resp_f !== 20'd13) begin errors++; $display("FAIL rm_next_f got=%0d exp=13", resp_f); end
      req = '0;
      wait_idle();
   endtask

   task automatic test_random();
      logic            ok;
      int              at;
      int              last;
      int              win;
      logic [NREQ-1:0] mask;
      logic [IW-1:0]   ix [NREQ];
      do_reset();
      last = NREQ - 1;
      for (int j = 0; j < 24; j++) begin
         mask    = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         eng_lat = int'($urandom_range(0, 5));
         for (int k = 0; k < NREQ; k++) begin
            ix[k] = IW'($urandom_range(0, (1 << IW) - 1));
            req_i[k*IW +: IW] = ix[k];
         end
         win = -1;
         for (int k = 1; k <= NREQ; k++) begin
            if (win < 0 && mask[(last + k) % NREQ]) win = (last + k) % NREQ;
         end
         req = mask;
         wait_resp(40, ok, at);
         checks++; if (!ok) begin errors++; $display("FAIL rand_timeout j=%0d got=none exp=resp", j); end
         checks++; if (resp_valid !== NREQ'(1 << win)) begin errors++; $display("FAIL rand_valid j=%0d got=%b exp=%b", j, resp_valid, NREQ'(1 << win)); end
         checks++; if (resp_f !== fib(int'(ix[win]))) begin errors++; $display("FAIL rand_f j=%0d got=%0d exp=%0d", j, resp_f, fib(int'(ix[win]))); end
         checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rand_err j=%0d got=%b exp=0", j, resp_err); end
         last = win;
         req  = '0;
         wait_idle();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_boundary();
      test_round_robin();
      test_watchdog();
      test_not_ready();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_time_limit got=running exp=finished");
      $fatal(1);
   end

endmodule
